// File: rtl/mips_cpu.sv
// Single-cycle MIPS subset: combinational fetch/decode/execute, one instruction per clock.
// PC, instruction memory, register file and data memory are separate instances for hierarchical observation.

module mips_pc (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    output logic [31:0] pc
);
    // Power-up value gives a defined PC even if rst is never asserted.
    logic [31:0] OUT = '0;

    always_ff @(posedge clk) begin
        if (rst) OUT <= '0;
        else     OUT <= next_pc;
    end

    assign pc = OUT;
endmodule

module mips_imem #(
    parameter int DEPTH = 256
) (
    input  logic [31:0] addr,
    output logic [31:0] instr
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] InstructionMemory [0:DEPTH-1];
    logic [31:0] word_idx;

    assign word_idx = {2'b00, addr[31:2]} % 32'(DEPTH);
    assign instr    = InstructionMemory[word_idx[AW-1:0]];
endmodule

module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] Registers [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) Registers[i] <= '0;
        end else if (we && wa != 5'd0) begin
            Registers[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : Registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : Registers[ra2];
endmodule

module mips_dmem #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] DataMemory [0:DEPTH-1];
    logic [31:0] word_idx;

    assign word_idx = {2'b00, addr[31:2]} % 32'(DEPTH);

    always_ff @(posedge clk) begin
        if (we) DataMemory[word_idx[AW-1:0]] <= wd;
    end

    assign rd = DataMemory[word_idx[AW-1:0]];
endmodule

module mips_cpu #(
    parameter int IM_DEPTH = 256,
    parameter int DM_DEPTH = 256
) (
    input logic clk,
    input logic rst
);
    logic [31:0] pc, next_pc, instr, pc_plus4;
    logic [31:0] rs_val, rt_val, sign_imm, zero_imm, mem_addr, mem_rd;
    logic [31:0] rf_wd;
    logic [4:0]  rf_wa;
    logic        rf_we, mem_we;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign sign_imm = {{16{instr[15]}}, instr[15:0]};
    assign zero_imm = {16'd0, instr[15:0]};
    assign pc_plus4 = pc + 32'd4;
    assign mem_addr = rs_val + sign_imm;

    mips_pc ProgCounter (.clk(clk), .rst(rst), .next_pc(next_pc), .pc(pc));

    mips_imem #(.DEPTH(IM_DEPTH)) IM (.addr(pc), .instr(instr));

    // Writes are suppressed while rst is high so the abandoned instruction leaves no trace.
    mips_regfile RF (
        .clk(clk), .rst(rst), .we(rf_we & ~rst), .wa(rf_wa), .wd(rf_wd),
        .ra1(rs), .ra2(rt), .rd1(rs_val), .rd2(rt_val)
    );

    mips_dmem #(.DEPTH(DM_DEPTH)) DM (
        .clk(clk), .we(mem_we & ~rst), .addr(mem_addr), .wd(rt_val), .rd(mem_rd)
    );

    always_comb begin
        next_pc = pc_plus4;
        rf_we   = 1'b0;
        rf_wa   = rt;
        rf_wd   = 32'd0;
        mem_we  = 1'b0;

        case (opcode)
            6'h00: begin
                rf_we = 1'b1;
                rf_wa = rd;
                case (funct)
                    6'h20, 6'h21: rf_wd = rs_val + rt_val;
                    6'h22, 6'h23: rf_wd = rs_val - rt_val;
                    6'h24:        rf_wd = rs_val & rt_val;
                    6'h25:        rf_wd = rs_val | rt_val;
                    6'h26:        rf_wd = rs_val ^ rt_val;
                    6'h27:        rf_wd = ~(rs_val | rt_val);
                    6'h2A:        rf_wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B:        rf_wd = {31'd0, rs_val < rt_val};
                    6'h00:        rf_wd = rt_val << shamt;
                    6'h02:        rf_wd = rt_val >> shamt;
                    6'h03:        rf_wd = $signed(rt_val) >>> shamt;
                    6'h08: begin
                        rf_we   = 1'b0;
                        next_pc = rs_val;
                    end
                    default:      rf_we = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin rf_we = 1'b1; rf_wd = rs_val + sign_imm; end
            6'h0A: begin rf_we = 1'b1; rf_wd = {31'd0, $signed(rs_val) < $signed(sign_imm)}; end
            6'h0B: begin rf_we = 1'b1; rf_wd = {31'd0, rs_val < sign_imm}; end
            6'h0C: begin rf_we = 1'b1; rf_wd = rs_val & zero_imm; end
            6'h0D: begin rf_we = 1'b1; rf_wd = rs_val | zero_imm; end
            6'h0E: begin rf_we = 1'b1; rf_wd = rs_val ^ zero_imm; end
            6'h0F: begin rf_we = 1'b1; rf_wd = {instr[15:0], 16'd0}; end
            6'h23: begin rf_we = 1'b1; rf_wd = mem_rd; end
            6'h2B: mem_we = 1'b1;
            6'h04: if (rs_val == rt_val) next_pc = pc_plus4 + {sign_imm[29:0], 2'b00};
            6'h05: if (rs_val != rt_val) next_pc = pc_plus4 + {sign_imm[29:0], 2'b00};
            6'h02: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            6'h03: begin
                next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
                rf_we   = 1'b1;
                rf_wa   = 5'd31;
                rf_wd   = pc_plus4;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: programs loaded hierarchically, expected architectural state queued
// when a program is set up and drained against the DUT once the program has run.

module tb_mips_cpu;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mips_cpu #(.IM_DEPTH(256), .DM_DEPTH(256)) dut (.clk(clk), .rst(rst));

    typedef struct {
        string       name;
        int          kind;   // 0 reg, 1 data mem, 2 pc, 3 cycle count
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];
    int          errors = 0;
    int          checks = 0;
    int          cycles_taken = 0;
    exp_t        e;
    logic [31:0] act;

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] jtype(int op, int target);
        return {6'(op), 26'(target)};
    endfunction

    function automatic logic [31:0] observe(int kind, int idx);
        case (kind)
            0:       return dut.RF.Registers[idx];
            1:       return dut.DM.DataMemory[idx];
            2:       return dut.ProgCounter.OUT;
            default: return 32'(cycles_taken);
        endcase
    endfunction

    function automatic void push(string n, int kind, int idx, logic [31:0] v);
        exp_t x;
        x.name = n; x.kind = kind; x.idx = idx; x.exp = v;
        sb.push_back(x);
    endfunction

    // Holds rst through one edge while the program is loaded; first instruction runs on the next edge.
    task automatic start_program(input bit clear_dm);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) dut.IM.InstructionMemory[i] = 32'd0;
        for (int i = 0; i < prog.size(); i++) dut.IM.InstructionMemory[i] = prog[i];
        if (clear_dm) for (int i = 0; i < 256; i++) dut.DM.DataMemory[i] = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        prog = '{};
        start_program(1'b1);
        push("reset_pc", 2, 0, 32'd0);
        for (int r = 0; r < 32; r++) push($sformatf("reset_r%0d", r), 0, r, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = observe(e.kind, e.idx); checks++;
            if (act !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, act, e.exp); end
        end
    endtask

    task automatic test_addi;
        prog = '{itype(8, 0, 8, 5), itype(8, 8, 9, -7)};
        start_program(1'b1);
        push("addi_t0", 0, 8, 32'h0000_0005);
        push("addi_t1", 0, 9, 32'hFFFF_FFFE);
        push("addi_pc", 2, 0, 32'h0000_0008);
        step(2);
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = observe(e.kind, e.idx); checks++;
            if (act !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, act, e.exp); end
        end
    endtask

    task automatic test_load_store;
        prog = '{itype(15, 0, 8, 16'h1234), itype(13, 8, 8, 16'h5678),
                 itype(43, 0, 8, 4), itype(35, 0, 9, 4)};
        start_program(1'b1);
        push("lw_t1", 0, 9, 32'h1234_5678);
        push("sw_dm1", 1, 1, 32'h1234_5678);
        push("ls_pc", 2, 0, 32'd16);
        step(4);
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = observe(e.kind, e.idx); checks++;
            if (act !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, act, e.exp); end
        end
    endtask

    // 7 -> odd dec 6 -> srl 3 -> dec 2 -> srl 1 -> dec 0 -> srl 0: three passes of five instructions.
    task automatic test_loop;
        prog = '{itype(8, 0, 8, 7),
                 itype(12, 8, 9, 1),
                 itype(4, 9, 0, 1),
                 itype(8, 8, 8, -1),
                 rtype(0, 8, 8, 1, 2),
                 itype(5, 8, 0, -5),
                 32'd0};
        start_program(1'b1);
        push("loop_t0", 0, 8, 32'd0);
        push("loop_t1", 0, 9, 32'd1);
        push("loop_exit_pc", 2, 0, 32'd24);
        push("loop_cycles", 3, 0, 32'd16);
        cycles_taken = 0;
        while (dut.ProgCounter.OUT !== 32'd24 && cycles_taken < 200) begin
            step(1);
            cycles_taken++;
        end
        if (cycles_taken >= 200) begin
            errors++; checks++;
            $display("FAIL loop_timeout: pc %h after %0d cycles, want 00000018", dut.ProgCounter.OUT, cycles_taken);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = observe(e.kind, e.idx); checks++;
            if (act !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, act, e.exp); end
        end
    endtask

    task automatic test_jal_jr;
        prog = '{jtype(3, 4), 32'd0, 32'd0, 32'd0, rtype(31, 0, 0, 0, 8)};
        start_program(1'b1);
        push("jal_target_pc", 2, 0, 32'd16);
        push("jal_ra", 0, 31, 32'd4);
        step(1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = observe(e.kind, e.idx); checks++;
            if (act !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, act, e.exp); end
        end
        push("jr_return_pc", 2, 0, 32'd4);
        push("jr_ra_kept", 0, 31, 32'd4);
        step(1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = observe(e.kind, e.idx); checks++;
            if (act !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, act, e.exp); end
        end
    endtask

    task automatic test_zero_overflow;
        prog = '{itype(8, 0, 0, 9), itype(15, 0, 8, 16'h7FFF), itype(13, 8, 8, 16'hFFFF),
                 itype(8, 0, 9, 1), rtype(8, 9, 10, 0, 6'h20), rtype(0, 0, 11, 0, 6'h25)};
        start_program(1'b1);
        push("zero_reg", 0, 0, 32'd0);
        push("add_wrap", 0, 10, 32'h8000_0000);
        push("zero_read", 0, 11, 32'd0);
        push("zero_pc", 2, 0, 32'd24);
        step(6);
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = observe(e.kind, e.idx); checks++;
            if (act !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, act, e.exp); end
        end
    endtask

    task automatic test_alu;
        logic [31:0] a, b;
        a = 32'hFFFF_FFF8;
        b = 32'd3;
        prog = '{itype(8, 0, 8, -8), itype(8, 0, 9, 3),
                 rtype(8, 9, 10, 0, 6'h22), rtype(8, 9, 11, 0, 6'h24),
                 rtype(8, 9, 12, 0, 6'h25), rtype(8, 9, 13, 0, 6'h26),
                 rtype(8, 9, 14, 0, 6'h27), rtype(8, 9, 15, 0, 6'h2A),
                 rtype(8, 9, 16, 0, 6'h2B), rtype(0, 9, 17, 4, 6'h00),
                 rtype(0, 8, 18, 1, 6'h02), rtype(0, 8, 19, 1, 6'h03),
                 itype(10, 8, 20, -1), itype(11, 9, 21, -1),
                 itype(12, 8, 22, 16'hFFF0), itype(14, 9, 23, 16'h8000),
                 itype(9, 9, 24, -5), itype(4, 9, 9, 1),
                 itype(8, 0, 26, 1), itype(63, 0, 27, 1),
                 rtype(8, 9, 28, 0, 6'h3F), itype(43, 0, 9, -4),
                 itype(35, 0, 25, -4), itype(5, 9, 9, 4)};
        start_program(1'b1);
        push("sub", 0, 10, a - b);
        push("and", 0, 11, a & b);
        push("or", 0, 12, a | b);
        push("xor", 0, 13, a ^ b);
        push("nor", 0, 14, ~(a | b));
        push("slt", 0, 15, 32'd1);
        push("sltu", 0, 16, 32'd0);
        push("sll", 0, 17, b << 4);
        push("srl", 0, 18, a >> 1);
        push("sra", 0, 19, 32'hFFFF_FFFC);
        push("slti", 0, 20, 32'd1);
        push("sltiu", 0, 21, 32'd1);
        push("andi_zext", 0, 22, 32'h0000_FFF0);
        push("xori_zext", 0, 23, 32'h0000_8003);
        push("addiu", 0, 24, 32'hFFFF_FFFE);
        push("beq_skipped", 0, 26, 32'd0);
        push("bad_opcode", 0, 27, 32'd0);
        push("bad_funct", 0, 28, 32'd0);
        push("sw_wrap_dm255", 1, 255, 32'd3);
        push("lw_wrap", 0, 25, 32'd3);
        push("alu_pc", 2, 0, 32'd96);
        step(23);
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = observe(e.kind, e.idx); checks++;
            if (act !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, act, e.exp); end
        end
    endtask

    task automatic test_mid_reset;
        prog = '{itype(8, 0, 8, 1), itype(8, 0, 9, 2), itype(43, 0, 9, 8), itype(43, 0, 9, 12)};
        start_program(1'b1);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        push("midrst_pc", 2, 0, 32'd0);
        for (int r = 0; r < 32; r++) push($sformatf("midrst_r%0d", r), 0, r, 32'd0);
        push("midrst_dm2_kept", 1, 2, 32'd2);
        push("midrst_dm3_blocked", 1, 3, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = observe(e.kind, e.idx); checks++;
            if (act !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, act, e.exp); end
        end
    endtask

    task automatic test_back_to_back;
        push("restart_t0", 0, 8, 32'd1);
        push("restart_t1", 0, 9, 32'd2);
        push("restart_pc", 2, 0, 32'd8);
        step(2);
        while (sb.size() > 0) begin
            e = sb.pop_front(); act = observe(e.kind, e.idx); checks++;
            if (act !== e.exp) begin errors++; $display("FAIL %s: got %h want %h", e.name, act, e.exp); end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_store();
        test_loop();
        test_jal_jr();
        test_zero_overflow();
        test_alu();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
